sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/arm_mem_pkg.sv | 31 +++
 rtl/sram_phase_timer.sv | 27 ++
 rtl/sram_controller.sv | 123 ++++++++++++
 tb/tb_sram_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory SRAM controller.
//   mem_state_t       : controller FSM states
//   SRAM_AW / SRAM_DW : external SRAM address / data widths
//   BASE_ADDR_DEFAULT : byte address where data memory starts
//   word_index()      : byte address -> 32-bit word index inside the SRAM
package arm_mem_pkg;

    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } mem_state_t;

    // Each 32-bit word occupies two halfwords, so the word index is the
    // offset from the base with the byte-in-word bits dropped. Offsets that
    // do not fit simply wrap (truncation is intended).
    function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] addr,
                                                      input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return offset[SRAM_AW:2];
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Phase timer for the SRAM controller.
//   clk   : clock
//   rst   : synchronous active-low reset
//   clear : restart counting from 0 on the next cycle
//   last  : high on the final cycle of a PHASE_CYC-cycle phase
module sram_phase_timer #(
    parameter int PHASE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic last
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= 4'd0;
        end else begin
            count <= count + 4'd1;
        end
    end

    assign last = (count == 4'(PHASE_CYC - 1));

endmodule

// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit asynchronous SRAM.
// Each access is split into a low and a high halfword phase of PHASE_CYC
// cycles; the pipeline is frozen (ready=0) from acceptance until DONE.
//   clk, rst        : clock, synchronous active-low reset
//   wr_en, rd_en    : store / load request (store wins if both)
//   address, wdata  : byte address and store data
//   rdata           : load result, valid while ready=1 in DONE
//   ready           : 0 = freeze pipeline this cycle
//   SRAM_*          : external SRAM bus and active-low strobes
//   fsm_state       : current FSM state, for observation
//
// Handshake: a request is taken when wr_en|rd_en is high in IDLE; the
// requester keeps it stable until it sees ready=1, which happens only in
// DONE. Inputs are ignored outside IDLE.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int          PHASE_CYC = 2,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output mem_state_t         fsm_state
);

    mem_state_t         state, state_next;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        wdata_q;
    logic [15:0]        lo_q;
    logic [31:0]        rdata_q;
    logic               last;
    logic               in_phase;
    logic               hi_phase;
    logic               dq_drive;
    logic [15:0]        dq_out;

    assign in_phase = (state == RD_LO) || (state == RD_HI) ||
                      (state == WR_LO) || (state == WR_HI);
    assign hi_phase = (state == RD_HI) || (state == WR_HI);

    // Held at zero outside the phases and restarted on every phase change,
    // so each phase starts counting from 0.
    sram_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(!in_phase || last),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_en)      state_next = WR_LO;
                else if (rd_en) state_next = RD_LO;
            end
            RD_LO:   if (last) state_next = RD_HI;
            RD_HI:   if (last) state_next = DONE;
            WR_LO:   if (last) state_next = WR_HI;
            WR_HI:   if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && (wr_en || rd_en)) begin
                word_q  <= word_index(address, BASE_ADDR);
                wdata_q <= wdata;
            end
            // Sample on the final phase cycle, when the SRAM output has
            // had the longest time to settle.
            if (state == RD_LO && last) lo_q    <= SRAM_DQ;
            if (state == RD_HI && last) rdata_q <= {SRAM_DQ, lo_q};
        end
    end

    assign SRAM_ADDR = in_phase ? {word_q, hi_phase} : '0;
    assign SRAM_OE_N = !((state == RD_LO) || (state == RD_HI));
    // WE_N rises one cycle before the phase ends so data is held past it.
    assign SRAM_WE_N = !(((state == WR_LO) || (state == WR_HI)) && !last);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign dq_drive = (state == WR_LO) || (state == WR_HI);
    assign dq_out   = (state == WR_HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ  = dq_drive ? dq_out : 16'hzzzz;

    // The acceptance cycle already freezes the pipeline.
    assign ready = (state == DONE) || ((state == IDLE) && !(rd_en || wr_en));

    assign rdata     = rdata_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
  import arm_mem_pkg::*;

  localparam int P = 2;
  localparam int P4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT, PHASE_CYC = 2 ----------------
  logic        wr_en = 0, rd_en = 0;
  logic [31:0] address = 0, wdata = 0;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
  mem_state_t  fsm_state;

  sram_controller #(.PHASE_CYC(P)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .fsm_state(fsm_state)
  );

  logic [15:0] sram_mem [0:4095];
  assign sram_dq = (!oe_n) ? sram_mem[sram_addr[11:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n) sram_mem[sram_addr[11:0]] <= sram_dq;

  // ---------------- DUT, PHASE_CYC = 4 ----------------
  logic        wr_en4 = 0, rd_en4 = 0;
  logic [31:0] address4 = 0, wdata4 = 0;
  logic [31:0] rdata4;
  logic        ready4;
  wire  [15:0] sram_dq4;
  logic [17:0] sram_addr4;
  logic        we_n4, oe_n4, ce_n4, ub_n4, lb_n4;
  mem_state_t  fsm_state4;

  sram_controller #(.PHASE_CYC(P4)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .rd_en(rd_en4), .address(address4),
    .wdata(wdata4), .rdata(rdata4), .ready(ready4), .SRAM_DQ(sram_dq4),
    .SRAM_ADDR(sram_addr4), .SRAM_WE_N(we_n4), .SRAM_OE_N(oe_n4),
    .SRAM_CE_N(ce_n4), .SRAM_UB_N(ub_n4), .SRAM_LB_N(lb_n4), .fsm_state(fsm_state4)
  );

  logic [15:0] sram_mem4 [0:63];
  assign sram_dq4 = (!oe_n4) ? sram_mem4[sram_addr4[5:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n4) sram_mem4[sram_addr4[5:0]] <= sram_dq4;

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int check_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_word [int];   // word index -> last stored value
  int          written[$];
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  // Presents a request in an IDLE cycle and follows it until ready=1.
  // Counts low-ready cycles and strobe cycles, and records the SRAM address
  // at the first and last strobed cycle.
  task automatic run_txn(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, output int cyc, output int we_cnt,
                         output int oe_cnt, output logic [17:0] fa, output logic [17:0] la);
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; wdata = d;
    #1;
    cyc = 0; we_cnt = 0; oe_cnt = 0; fa = '0; la = '0;
    while (!ready && cyc < 40) begin
      if (!we_n || !oe_n) begin
        if (we_cnt + oe_cnt == 0) fa = sram_addr;
        la = sram_addr;
      end
      if (!we_n) we_cnt++;
      if (!oe_n) oe_cnt++;
      cyc++;
      @(negedge clk);
      #1;
    end
    wr_en = 0; rd_en = 0;
  endtask

  task automatic run_txn4(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output int cyc, output int we_cnt,
                          output int oe_cnt);
    @(negedge clk);
    wr_en4 = w; rd_en4 = r; address4 = a; wdata4 = d;
    #1;
    cyc = 0; we_cnt = 0; oe_cnt = 0;
    while (!ready4 && cyc < 60) begin
      if (!we_n4) we_cnt++;
      if (!oe_n4) oe_cnt++;
      cyc++;
      @(negedge clk);
      #1;
    end
    wr_en4 = 0; rd_en4 = 0;
  endtask

  function automatic logic [31:0] word_addr(input int w);
    return 32'd1024 + 32'(w) * 32'd4;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cyc, wc, oc;
    logic [17:0] fa, la;
    logic [31:0] d, a;
    int w;

    // reset
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, we_n}, 32'd1);
    check("rst_oe_n", {31'd0, oe_n}, 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_state", {29'd0, fsm_state}, {29'd0, IDLE});
    check("strobes_tied", {29'd0, ce_n, ub_n, lb_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("idle_ready", {31'd0, ready}, 32'd1);

    // write then read at the base address
    run_txn(1, 0, 32'd1024, 32'hDEADBEEF, cyc, wc, oc, fa, la);
    check("wr0_cycles", cyc, 2 * P + 1);
    check("wr0_we_cnt", wc, 2 * (P - 1));
    check("wr0_oe_cnt", oc, 0);
    check("wr0_addr_lo", {14'd0, fa}, 32'd0);
    check("wr0_addr_hi", {14'd0, la}, 32'd1);
    check("wr0_mem_lo", {16'd0, sram_mem[0]}, 32'h0000BEEF);
    check("wr0_mem_hi", {16'd0, sram_mem[1]}, 32'h0000DEAD);
    ref_word[0] = 32'hDEADBEEF; written.push_back(0);
    run_txn(0, 1, 32'd1024, 32'd0, cyc, wc, oc, fa, la);
    exp_q.push_back(ref_word[0]);
    check("rd0_cycles", cyc, 2 * P + 1);
    check("rd0_oe_cnt", oc, 2 * P);
    check("rd0_we_cnt", wc, 0);
    check("rd0_rdata", rdata, exp_q.pop_front());
    last_rd = 32'hDEADBEEF;
    @(negedge clk);
    #1;
    check("rdata_hold", rdata, last_rd);
    check("idle_we_oe", {30'd0, we_n, oe_n}, 32'd3);

    // address map: byte-in-word bits ignored
    d = $urandom;
    run_txn(1, 0, 32'd1039, d, cyc, wc, oc, fa, la);
    check("map_addr_lo", {14'd0, fa}, 32'd6);
    check("map_addr_hi", {14'd0, la}, 32'd7);
    check("map_mem", {sram_mem[7], sram_mem[6]}, d);
    ref_word[3] = d; written.push_back(3);

    // write wins over read
    run_txn(1, 1, 32'd1028, 32'h12345678, cyc, wc, oc, fa, la);
    check("both_oe_cnt", oc, 0);
    check("both_cycles", cyc, 2 * P + 1);
    check("both_mem", {sram_mem[3], sram_mem[2]}, 32'h12345678);
    check("both_rdata_hold", rdata, last_rd);
    ref_word[1] = 32'h12345678; written.push_back(1);

    // back-to-back: two stores to one address, then a load
    run_txn(1, 0, word_addr(10), 32'hA5A5_0001, cyc, wc, oc, fa, la);
    check("b2b_wr1_cycles", cyc, 2 * P + 1);
    run_txn(1, 0, word_addr(10), 32'h5A5A_0002, cyc, wc, oc, fa, la);
    check("b2b_wr2_cycles", cyc, 2 * P + 1);
    ref_word[10] = 32'h5A5A_0002; written.push_back(10);
    run_txn(0, 1, word_addr(10), 32'd0, cyc, wc, oc, fa, la);
    exp_q.push_back(ref_word[10]);
    check("b2b_rd_cycles", cyc, 2 * P + 1);
    check("b2b_rd_rdata", rdata, exp_q.pop_front());
    last_rd = ref_word[10];

    // randomized traffic against the word-level model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = $urandom_range(0, 1999);
        d = $urandom;
        a = word_addr(w) + 32'($urandom_range(0, 3));
        run_txn(1, 0, a, d, cyc, wc, oc, fa, la);
        check("rnd_wr_cycles", cyc, 2 * P + 1);
        check("rnd_wr_mem", {sram_mem[2 * w + 1], sram_mem[2 * w]}, d);
        check("rnd_wr_rdata_hold", rdata, last_rd);
        ref_word[w] = d;
        written.push_back(w);
      end else begin
        w = written[$urandom_range(0, written.size() - 1)];
        a = word_addr(w) + 32'($urandom_range(0, 3));
        run_txn(0, 1, a, 32'($urandom), cyc, wc, oc, fa, la);
        exp_q.push_back(ref_word[w]);
        check("rnd_rd_cycles", cyc, 2 * P + 1);
        check("rnd_rd_addr", {14'd0, fa}, 32'(2 * w));
        check("rnd_rd_rdata", rdata, exp_q.pop_front());
        last_rd = ref_word[w];
      end
    end

    // reset in the second cycle of the high write phase
    @(negedge clk);
    wr_en = 1; address = word_addr(2000); wdata = $urandom;
    repeat (P + 2) @(negedge clk);
    #1;
    check("mid_state", {29'd0, fsm_state}, {29'd0, WR_HI});
    rst = 1'b0; wr_en = 0;
    @(negedge clk);
    #1;
    check("mid_rst_state", {29'd0, fsm_state}, {29'd0, IDLE});
    check("mid_rst_we_n", {31'd0, we_n}, 32'd1);
    check("mid_rst_oe_n", {31'd0, oe_n}, 32'd1);
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_rdata", rdata, 32'd0);
    rst = 1'b1;
    last_rd = 32'd0;

    // longer phases
    d = $urandom;
    run_txn4(1, 0, 32'd1024 + 32'd16, d, cyc, wc, oc);
    check("p4_wr_cycles", cyc, 2 * P4 + 1);
    check("p4_wr_we_cnt", wc, 2 * (P4 - 1));
    check("p4_wr_mem", {sram_mem4[9], sram_mem4[8]}, d);
    run_txn4(0, 1, 32'd1024 + 32'd16, 32'd0, cyc, wc, oc);
    check("p4_rd_cycles", cyc, 2 * P4 + 1);
    check("p4_rd_oe_cnt", oc, 2 * P4);
    check("p4_rd_rdata", rdata4, d);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
